// File: rtl/td4_run_ctrl.sv
// rtl/td4_run_ctrl.sv - TD4 run/step controller and 16x8 program store
//
// Purpose:
//   Holds the TD4 instruction memory and serves op_o = mem[ip_i] to the core.
//   Generates the core clock-enable and active-low core reset so a host can
//   load a program, run it at a divided rate, stop it, single-step it and
//   reset it. The core advances only on edges where core_ce_o = 1.
//
// Build option:
//   TD4_BREAKPOINT_EN - when defined, RUNNING halts instead of executing the
//   instruction at bp_addr_i (bp_en_i = 1) and pulses bp_hit_o. When not
//   defined, bp_en_i/bp_addr_i are ignored and bp_hit_o is 0.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i, cmd_i    command request (00 CORE_RST, 01 RUN, 10 STOP, 11 STEP)
//   cmd_ready_o           command accepted when cmd_valid_i & cmd_ready_o
//   wr_en_i, wr_addr_i,   program-memory write
//   wr_data_i
//   wr_err_o              one-cycle pulse: write dropped (core running/stepping)
//   div_cfg_i             run rate: one instruction every div_cfg_i+1 cycles
//   ip_i, op_o            core instruction pointer, combinational mem[ip_i]
//   core_ce_o             core clock-enable
//   core_rst_n_o          core reset, active-low
//   running_o             high in RUNNING
//   instr_cnt_o           core_ce_o cycles since last core reset, wraps
//   bp_en_i, bp_addr_i    breakpoint enable / address
//   bp_hit_o              one-cycle pulse on breakpoint halt

module td4_run_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  input  logic [1:0]       cmd_i,
  output logic             cmd_ready_o,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_addr_i,
  input  logic [7:0]       wr_data_i,
  output logic             wr_err_o,
  input  logic [DIV_W-1:0] div_cfg_i,
  input  logic [3:0]       ip_i,
  output logic [7:0]       op_o,
  output logic             core_ce_o,
  output logic             core_rst_n_o,
  output logic             running_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  input  logic             bp_en_i,
  input  logic [3:0]       bp_addr_i,
  output logic             bp_hit_o
);

  typedef enum logic [1:0] {
    S_RESETTING = 2'b00,
    S_HALTED    = 2'b01,
    S_RUNNING   = 2'b10,
    S_STEP      = 2'b11
  } state_e;

  localparam logic [1:0] CMD_CORE_RST = 2'b00;
  localparam logic [1:0] CMD_RUN      = 2'b01;
  localparam logic [1:0] CMD_STOP     = 2'b10;
  localparam logic [1:0] CMD_STEP     = 2'b11;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             rst_cnt_q, rst_cnt_d;     // core reset lasts two cycles: counts 0,1
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [7:0]       mem_q [16];

  logic cmd_ready_q, running_q, core_rst_n_q, wr_err_q, bp_hit_q;

  logic cmd_acc;
  logic div_match;
  logic bp_stop;
  logic core_ce;
  logic core_rst_req;
  logic wr_legal;
  logic wr_err_d;
  logic bp_hit_d;

`ifdef TD4_BREAKPOINT_EN
  // Breakpoint only matters on an edge where RUNNING would otherwise execute.
  assign bp_stop = (state_q == S_RUNNING) & div_match & bp_en_i & (ip_i == bp_addr_i);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en_i, bp_addr_i};
  assign bp_stop   = 1'b0;
`endif

  // cmd_ready_q is a registered decode of state, so acceptance never depends
  // combinationally on cmd_valid_i feeding back into cmd_ready_o.
  assign cmd_acc   = cmd_valid_i & cmd_ready_q;
  assign div_match = (div_q == div_cfg_i);

  // core_ce depends on the live div_cfg_i so a rate change applies at once;
  // a STEP cycle always executes, which is how a breakpoint is stepped past.
  assign core_ce = ((state_q == S_RUNNING) & div_match & ~bp_stop) | (state_q == S_STEP);

  // Writes are judged on the state before the edge.
  assign wr_legal = (state_q == S_HALTED) | (state_q == S_RESETTING);

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    div_d        = div_q;
    core_rst_req = 1'b0;

    case (state_q)
      S_RESETTING: begin
        if (rst_cnt_q) begin
          state_d   = S_HALTED;
          rst_cnt_d = 1'b0;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      S_HALTED: begin
        if (cmd_acc) begin
          case (cmd_i)
            CMD_RUN: begin
              state_d = S_RUNNING;
              div_d   = '0;
            end
            CMD_STEP:     state_d      = S_STEP;
            CMD_CORE_RST: core_rst_req = 1'b1;
            default:      state_d      = S_HALTED;
          endcase
        end
      end
      S_RUNNING: begin
        // Equality compare: if div_cfg drops below the count, the counter
        // runs on through its natural wrap before matching again.
        div_d = div_match ? '0 : (div_q + DIV_ONE);
        if (bp_stop) begin
          state_d = S_HALTED;
        end
        if (cmd_acc) begin
          if (cmd_i == CMD_STOP) begin
            state_d = S_HALTED;
          end else if (cmd_i == CMD_CORE_RST) begin
            core_rst_req = 1'b1;
          end
        end
      end
      S_STEP: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_RESETTING;
      end
    endcase

    if (core_rst_req) begin
      state_d   = S_RESETTING;
      rst_cnt_d = 1'b0;
    end
  end

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (core_rst_req) begin
      instr_cnt_d = '0;
    end else if (core_ce) begin
      instr_cnt_d = instr_cnt_q + CNT_ONE;
    end
  end

  assign wr_err_d = wr_en_i & ~wr_legal;
  // A core reset issued on the same edge takes precedence over the halt report.
  assign bp_hit_d = bp_stop & ~core_rst_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_RESETTING;
      rst_cnt_q    <= 1'b0;
      div_q        <= '0;
      instr_cnt_q  <= '0;
      cmd_ready_q  <= 1'b0;
      running_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      wr_err_q     <= 1'b0;
      bp_hit_q     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      div_q        <= div_d;
      instr_cnt_q  <= instr_cnt_d;
      // Status outputs are registered from the next state so they line up
      // with state_q in every cycle.
      cmd_ready_q  <= (state_d == S_HALTED) | (state_d == S_RUNNING);
      running_q    <= (state_d == S_RUNNING);
      core_rst_n_q <= (state_d != S_RESETTING);
      wr_err_q     <= wr_err_d;
      bp_hit_q     <= bp_hit_d;
      if (wr_en_i && wr_legal) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign op_o         = mem_q[ip_i];
  assign core_ce_o    = core_ce;
  assign cmd_ready_o  = cmd_ready_q;
  assign running_o    = running_q;
  assign core_rst_n_o = core_rst_n_q;
  assign instr_cnt_o  = instr_cnt_q;
  assign wr_err_o     = wr_err_q;
  assign bp_hit_o     = bp_hit_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb/tb_td4_run_ctrl.sv - scoreboard bench for td4_run_ctrl
module tb_td4_run_ctrl;
  localparam int DIV_W = 8;
  localparam int CNT_W = 16;

  localparam logic [1:0] CMD_CORE_RST = 2'b00;
  localparam logic [1:0] CMD_RUN      = 2'b01;
  localparam logic [1:0] CMD_STOP     = 2'b10;
  localparam logic [1:0] CMD_STEP     = 2'b11;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cmd_valid_i;
  logic [1:0]       cmd_i;
  logic             cmd_ready_o;
  logic             wr_en_i;
  logic [3:0]       wr_addr_i;
  logic [7:0]       wr_data_i;
  logic             wr_err_o;
  logic [DIV_W-1:0] div_cfg_i;
  logic [3:0]       ip_i;
  logic [7:0]       op_o;
  logic             core_ce_o;
  logic             core_rst_n_o;
  logic             running_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic             bp_en_i;
  logic [3:0]       bp_addr_i;
  logic             bp_hit_o;

  td4_run_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i), .cmd_ready_o(cmd_ready_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_err_o(wr_err_o),
    .div_cfg_i(div_cfg_i), .ip_i(ip_i), .op_o(op_o),
    .core_ce_o(core_ce_o), .core_rst_n_o(core_rst_n_o), .running_o(running_o),
    .instr_cnt_o(instr_cnt_o),
    .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .bp_hit_o(bp_hit_o)
  );

  always #5 clk_i = ~clk_i;

  // cyc == k during the cycle that follows edge k.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: cycle numbers in which each pulse output must be high.
  int exp_ce_q[$];
  int exp_werr_q[$];
  int exp_bp_q[$];

  // Reference model state.
  logic [7:0] model_mem [16];
  int         exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (core_ce_o === 1'b1) begin
      if (exp_ce_q.size() == 0) check("ce_unexpected", core_ce_o, 1'b0);
      else check("ce_cycle", cyc, exp_ce_q.pop_front());
    end
    if (wr_err_o === 1'b1) begin
      if (exp_werr_q.size() == 0) check("wr_err_unexpected", wr_err_o, 1'b0);
      else check("wr_err_cycle", cyc, exp_werr_q.pop_front());
    end
    if (bp_hit_o === 1'b1) begin
      if (exp_bp_q.size() == 0) check("bp_hit_unexpected", bp_hit_o, 1'b0);
      else check("bp_hit_cycle", cyc, exp_bp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a command and returns the edge at which it was accepted.
  task automatic send_cmd(input logic [1:0] c, output int acc_edge);
    int w;
    w = 0;
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    while (cmd_ready_o !== 1'b1 && w < 8) begin
      tick();
      w++;
    end
    if (w == 8) check("cmd_ready_timeout", cmd_ready_o, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    acc_edge    = cyc;
  endtask

  task automatic check_halted(input string name);
    check({name, "_running"}, running_o, 1'b0);
    check({name, "_ready"}, cmd_ready_o, 1'b1);
    check({name, "_rst_n"}, core_rst_n_o, 1'b1);
    check({name, "_instr_cnt"}, instr_cnt_o, 32'(exp_cnt % (1 << CNT_W)));
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; ip_i = a;
    #1;
    check("op_before_write", op_o, model_mem[a]);
    tick();
    wr_en_i = 1'b0;
    model_mem[a] = d;
    check("op_after_write", op_o, model_mem[a]);
  endtask

  task automatic do_step();
    int n;
    send_cmd(CMD_STEP, n);
    exp_ce_q.push_back(n);
    exp_cnt++;
    check("step_ready_low", cmd_ready_o, 1'b0);
    check("step_ce", core_ce_o, 1'b1);
    tick();
    check_halted("after_step");
  endtask

  // RUN for len cycles, then STOP (or CORE_RST); optional dropped write.
  task automatic do_run(input int d, input int len, input bit do_err,
                        input logic [3:0] ea, input logic [7:0] ed, input bit end_rst);
    int n;
    div_cfg_i = DIV_W'(d);
    send_cmd(CMD_RUN, n);
    check("run_running", running_o, 1'b1);
    for (int k = 0; k < len; k++) begin
      if (k % (d + 1) == d) begin
        exp_ce_q.push_back(n + k);
        exp_cnt++;
      end
    end
    for (int k = 0; k < len; k++) begin
      ip_i = 4'($urandom_range(0, 15));
      if (do_err && k == 0) begin
        wr_en_i = 1'b1; wr_addr_i = ea; wr_data_i = ed;
        exp_werr_q.push_back(n + 1);
      end
      if (k == len - 1) begin
        cmd_valid_i = 1'b1;
        cmd_i = end_rst ? CMD_CORE_RST : CMD_STOP;
      end
      tick();
      wr_en_i = 1'b0;
    end
    cmd_valid_i = 1'b0;
    if (end_rst) begin
      exp_cnt = 0;
      check("crst_rst_n_0", core_rst_n_o, 1'b0);
      check("crst_ready_0", cmd_ready_o, 1'b0);
      check("crst_cnt", instr_cnt_o, 0);
      tick();
      check("crst_rst_n_1", core_rst_n_o, 1'b0);
      tick();
    end
    check_halted(end_rst ? "after_crst" : "after_stop");
  endtask

  task automatic do_core_rst_halted();
    int n;
    logic [3:0] a;
    logic [7:0] d;
    a = 4'($urandom_range(0, 15));
    d = 8'($urandom_range(0, 255));
    send_cmd(CMD_CORE_RST, n);
    exp_cnt = 0;
    check("hcrst_rst_n_0", core_rst_n_o, 1'b0);
    // A write while the core is held in reset is legal.
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; ip_i = a;
    tick();
    wr_en_i = 1'b0;
    model_mem[a] = d;
    check("hcrst_op", op_o, d);
    check("hcrst_rst_n_1", core_rst_n_o, 1'b0);
    tick();
    check_halted("after_hcrst");
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    int op_sel;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = CMD_STOP; wr_en_i = 1'b0;
    wr_addr_i = '0; wr_data_i = '0; div_cfg_i = '0; ip_i = '0;
    bp_en_i = 1'b0; bp_addr_i = '0;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    // Reset and boot sequence.
    repeat (3) tick();
    check("rst_core_rst_n", core_rst_n_o, 1'b0);
    check("rst_core_ce", core_ce_o, 1'b0);
    check("rst_cmd_ready", cmd_ready_o, 1'b0);
    check("rst_running", running_o, 1'b0);
    check("rst_wr_err", wr_err_o, 1'b0);
    check("rst_bp_hit", bp_hit_o, 1'b0);
    check("rst_instr_cnt", instr_cnt_o, 0);
    rst_i = 1'b0;
    check("boot_rst_n_c0", core_rst_n_o, 1'b0);
    tick();
    check("boot_rst_n_c1", core_rst_n_o, 1'b0);
    check("boot_ready_c1", cmd_ready_o, 1'b0);
    tick();
    check_halted("boot");
    for (int i = 0; i < 16; i++) begin
      ip_i = 4'(i);
      #1;
      check("boot_op_zero", op_o, 8'h00);
    end

    // Load and read back, then the same address written while running.
    do_write(4'd3, 8'hB5);
    do_run(3, 20, 1'b1, 4'd3, 8'h5A, 1'b0);
    check("run_div3_cnt", instr_cnt_o, 5);
    ip_i = 4'd3;
    #1;
    check("dropped_write_op", op_o, 8'hB5);

    // Core reset mid-run at full rate, then three single steps.
    do_run(0, 7, 1'b0, 4'd0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) do_step();
    check("three_steps_cnt", instr_cnt_o, 3);

    // Lowering div_cfg below the live count forces a wrap before matching.
    div_cfg_i = DIV_W'(10);
    send_cmd(CMD_RUN, n);
    exp_ce_q.push_back(n + 258);
    exp_ce_q.push_back(n + 261);
    exp_cnt += 2;
    repeat (5) tick();
    div_cfg_i = DIV_W'(2);
    repeat (256) tick();
    send_cmd(CMD_STOP, n);
    check_halted("after_wrap");

    // Breakpoint scenario: ip walks 0..5 with bp_addr=5.
    bp_en_i = 1'b1; bp_addr_i = 4'd5; div_cfg_i = '0; ip_i = 4'd0;
    send_cmd(CMD_RUN, n);
    ip_i = 4'd0;
`ifdef TD4_BREAKPOINT_EN
    for (int k = 0; k < 5; k++) exp_ce_q.push_back(n + k);
    exp_cnt += 5;
    exp_bp_q.push_back(n + 6);
    for (int k = 1; k <= 5; k++) begin tick(); ip_i = 4'(k); end
    tick();
    check_halted("bp_halt");
    do_step();
    send_cmd(CMD_RUN, n);
    exp_bp_q.push_back(n + 1);
    tick();
    check_halted("bp_rerun");
`else
    for (int k = 0; k < 6; k++) exp_ce_q.push_back(n + k);
    exp_cnt += 6;
    for (int k = 1; k <= 5; k++) begin tick(); ip_i = 4'(k); end
    send_cmd(CMD_STOP, n);
    check_halted("bp_ignored");
`endif
    bp_en_i = 1'b0;

    // Randomised operation mix checked against the model.
    for (int it = 0; it < 40; it++) begin
`ifndef TD4_BREAKPOINT_EN
      bp_en_i   = 1'($urandom_range(0, 1));
      bp_addr_i = 4'($urandom_range(0, 15));
`endif
      op_sel = $urandom_range(0, 3);
      case (op_sel)
        0: do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        1: do_step();
        2: do_run($urandom_range(0, 5), $urandom_range(1, 30), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 4) == 0));
        default: do_core_rst_halted();
      endcase
    end

    for (int i = 0; i < 16; i++) begin
      ip_i = 4'(i);
      #1;
      check("final_mem", op_o, model_mem[i]);
    end
    repeat (4) tick();
    check("ce_queue_drained", exp_ce_q.size(), 0);
    check("wr_err_queue_drained", exp_werr_q.size(), 0);
    check("bp_queue_drained", exp_bp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
